hub75_scan_driver: RTL and testbench

- Drives a 64x64 HUB75 LED panel at 1/32 scan.
- Sequences row/column addresses into the temperature pixel generator, which sits directly upstream.
- Samples the 24-bit RGB it returns and shifts top and bottom half-rows into the panel, then latches and displays each row.
- Sits between the pixel generator and the panel connector, on the single system clock.

---
 rtl/hub75_pkg.sv | 43 ++++
 rtl/hub75_color_slice.sv | 31 +++
 rtl/hub75_scan_driver.sv | 161 ++++++++++++++++
 tb/tb_hub75_scan_driver.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
//============================================================================
// Module : hub75_pkg
// Brief  : Shared FSM encoding, channel offsets and plane setup for the HUB75
//          scan driver. HUB75_BCM_EN selects 4-plane binary-coded modulation.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package hub75_pkg;

  localparam int R_OFF = 16;
  localparam int G_OFF = 8;
  localparam int B_OFF = 0;

  localparam int NUM_PLANES    = 4;
  localparam int DEF_COLS      = 64;
  localparam int DEF_HALF_ROWS = 32;
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_ON_CYCLES = 256;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE     = 4'd0;
  localparam state_t S_ADDR_TOP = 4'd1;
  localparam state_t S_CAP_TOP  = 4'd2;
  localparam state_t S_CAP_BOT  = 4'd3;
  localparam state_t S_SHIFT_LO = 4'd4;
  localparam state_t S_SHIFT_HI = 4'd5;
  localparam state_t S_BLANK    = 4'd6;
  localparam state_t S_LATCH    = 4'd7;
  localparam state_t S_DISPLAY  = 4'd8;

`ifdef HUB75_BCM_EN
  localparam int         PLANES_USED = NUM_PLANES;
  localparam logic [2:0] BASE_BIT    = 3'd4;
`else
  localparam int         PLANES_USED = 1;
  localparam logic [2:0] BASE_BIT    = 3'd7;
`endif

endpackage

`default_nettype wire

// File: rtl/hub75_color_slice.sv
//============================================================================
// Module : hub75_color_slice
// Brief  : Picks the active bit-plane of each colour channel from a 24-bit
//          pixel. Plane base bit depends on HUB75_BCM_EN (via hub75_pkg).
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module hub75_color_slice
  import hub75_pkg::*;
(
  input  logic [23:0] i_pixel,
  input  logic [1:0]  i_plane,
  output logic [2:0]  o_rgb
);

  logic [2:0] w_idx;
  logic [7:0] w_r;
  logic [7:0] w_g;
  logic [7:0] w_b;

  // Without BCM the plane index is always 0, so this resolves to bit 7.
  assign w_idx = BASE_BIT + {1'b0, i_plane};
  assign w_r   = i_pixel[R_OFF +: 8];
  assign w_g   = i_pixel[G_OFF +: 8];
  assign w_b   = i_pixel[B_OFF +: 8];
  assign o_rgb = {w_r[w_idx], w_g[w_idx], w_b[w_idx]};

endmodule

`default_nettype wire

// File: rtl/hub75_scan_driver.sv
//============================================================================
// Module : hub75_scan_driver
// Brief  : 64x64 1/32-scan HUB75 driver: fetches top/bottom pixels, shifts,
//          latches and displays each row. HUB75_BCM_EN enables 4-plane BCM.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module hub75_scan_driver
  import hub75_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int HALF_ROWS = DEF_HALF_ROWS,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int ON_CYCLES = DEF_ON_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [23:0] i_pixel_data,
  output logic [11:0] o_pixel_addr,
  output logic        o_r1,
  output logic        o_g1,
  output logic        o_b1,
  output logic        o_r2,
  output logic        o_g2,
  output logic        o_b2,
  output logic        o_sclk,
  output logic        o_lat,
  output logic        o_oe_n,
  output logic [4:0]  o_row_addr,
  output logic        o_frame_start
);

  localparam int         CNT_W      = $clog2(ON_CYCLES << (NUM_PLANES - 1)) + 1;
  localparam logic [1:0] LAST_PLANE = 2'(PLANES_USED - 1);
  localparam logic [5:0] LAST_COL   = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW   = 5'(HALF_ROWS - 1);

  state_t           r_state;
  logic [4:0]       r_row;
  logic [5:0]       r_col;
  logic [1:0]       r_plane;
  logic [CNT_W-1:0] r_cnt;
  logic [23:0]      r_top;
  logic [11:0]      r_pixel_addr;
  logic [2:0]       r_rgb_top;
  logic [2:0]       r_rgb_bot;
  logic [4:0]       r_row_addr;

  logic [2:0]       w_rgb_top;
  logic [2:0]       w_rgb_bot;
  logic [5:0]       w_bot_row;
  logic [CNT_W-1:0] w_on_len;

  assign w_bot_row = 6'(r_row) + 6'(HALF_ROWS);
  assign w_on_len  = CNT_W'(ON_CYCLES) << r_plane;

  hub75_color_slice u_slice_top (
    .i_pixel (r_top),
    .i_plane (r_plane),
    .o_rgb   (w_rgb_top)
  );

  // Bottom pixel is sliced straight off the generator in CAP_BOT.
  hub75_color_slice u_slice_bot (
    .i_pixel (i_pixel_data),
    .i_plane (r_plane),
    .o_rgb   (w_rgb_bot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_plane      <= '0;
      r_cnt        <= '0;
      r_top        <= '0;
      r_pixel_addr <= '0;
      r_rgb_top    <= '0;
      r_rgb_bot    <= '0;
      r_row_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_enable) r_state <= S_ADDR_TOP;
        end
        S_ADDR_TOP: begin
          r_pixel_addr <= {6'(r_row), r_col};
          r_state      <= S_CAP_TOP;
        end
        S_CAP_TOP: begin
          r_top        <= i_pixel_data;
          r_pixel_addr <= {w_bot_row, r_col};
          r_state      <= S_CAP_BOT;
        end
        S_CAP_BOT: begin
          r_rgb_top <= w_rgb_top;
          r_rgb_bot <= w_rgb_bot;
          r_cnt     <= CNT_W'(CLK_DIV - 1);
          r_state   <= S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          if (r_cnt == '0) begin
            r_cnt   <= CNT_W'(CLK_DIV - 1);
            r_state <= S_SHIFT_HI;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SHIFT_HI: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_col == LAST_COL) begin
            // Row select changes on BLANK entry so it is stable while dark.
            r_col      <= '0;
            r_row_addr <= r_row;
            r_state    <= S_BLANK;
          end else begin
            r_col   <= r_col + 6'd1;
            r_state <= S_ADDR_TOP;
          end
        end
        S_BLANK: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_cnt   <= w_on_len - 1'b1;
          r_state <= S_DISPLAY;
        end
        S_DISPLAY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_plane == LAST_PLANE) begin
            r_plane <= '0;
            r_row   <= (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;
            r_state <= i_enable ? S_ADDR_TOP : S_IDLE;
          end else begin
            r_plane <= r_plane + 2'd1;
            r_state <= S_ADDR_TOP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_pixel_addr  = r_pixel_addr;
  assign {o_r1, o_g1, o_b1} = r_rgb_top;
  assign {o_r2, o_g2, o_b2} = r_rgb_bot;
  assign o_row_addr    = r_row_addr;
  assign o_sclk        = (r_state == S_SHIFT_HI);
  assign o_lat         = (r_state == S_LATCH);
  assign o_oe_n        = (r_state != S_DISPLAY);
  assign o_frame_start = (r_state == S_ADDR_TOP) && (r_col == '0) &&
                         (r_row == '0) && (r_plane == '0);

endmodule

`default_nettype wire

// File: tb/tb_hub75_scan_driver.sv
//============================================================================
// Module : tb_hub75_scan_driver
// Brief  : Directed self-checking bench for hub75_scan_driver (HUB75_BCM_EN
//          selects the bit-plane scenario instead of the single-plane ones).
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_hub75_scan_driver;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [23:0] pixel_data;
  logic [11:0] pixel_addr;
  logic        r1, g1, b1, r2, g2, b2;
  logic        sclk, lat, oe_n, frame_start;
  logic [4:0]  row_addr;
  logic        bcm_mode;

  int total;
  int bad;

  hub75_scan_driver dut (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (enable),
    .i_pixel_data  (pixel_data),
    .o_pixel_addr  (pixel_addr),
    .o_r1          (r1),
    .o_g1          (g1),
    .o_b1          (b1),
    .o_r2          (r2),
    .o_g2          (g2),
    .o_b2          (b2),
    .o_sclk        (sclk),
    .o_lat         (lat),
    .o_oe_n        (oe_n),
    .o_row_addr    (row_addr),
    .o_frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel generator stand-in: red on the top half, blue on the bottom half.
  always_comb begin
    pixel_data = 24'h0000FF;
    if (bcm_mode) pixel_data = 24'h300000;
    else if (pixel_addr[11:6] < 6'd32) pixel_data = 24'hFF0000;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    enable = 1'b0;
    tick();
    total++;
    if ({pixel_addr, r1, g1, b1, r2, g2, b2, sclk, lat, oe_n, row_addr, frame_start} !==
        {12'h000, 6'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got addr=%h rgb=%b sclk=%b lat=%b oe_n=%b row=%0d fs=%b, expected 000/000000/0/0/1/0/0",
               pixel_addr, {r1, g1, b1, r2, g2, b2}, sclk, lat, oe_n, row_addr, frame_start);
    end
    rst = 1'b0;
    enable = 1'b1;
    n = 0;
    while (sclk !== 1'b1 && n < 30) begin tick(); n++; end
    total++;
    if (sclk !== 1'b1) begin
      bad++;
      $display("FAIL reach_shift_hi: sclk=%b expected 1", sclk);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({oe_n, sclk, lat, pixel_addr} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
      bad++;
      $display("FAIL async_reset: got oe_n=%b sclk=%b lat=%b addr=%h expected 1/0/0/000",
               oe_n, sclk, lat, pixel_addr);
    end
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    while (frame_start !== 1'b1 && n < 10) begin tick(); n++; end
    total++;
    if (frame_start !== 1'b1) begin
      bad++;
      $display("FAIL frame_start_after_reset: got %b expected 1", frame_start);
    end
    tick();
    total++;
    if (pixel_addr !== 12'h000) begin
      bad++;
      $display("FAIL first_addr: got %h expected 000", pixel_addr);
    end
    tick();
    total++;
    if (pixel_addr !== 12'h800) begin
      bad++;
      $display("FAIL first_bot_addr: got %h expected 800", pixel_addr);
    end
  endtask

  task automatic test_colors();
    int edges;
    int lats;
    int n;
    logic prev;
    edges = 0;
    lats = 0;
    n = 0;
    prev = sclk;
    while (lats < 2 && n < 2000) begin
      tick();
      n++;
      if (sclk && !prev) begin
        edges++;
        total++;
        if ({r1, g1, b1, r2, g2, b2} !== 6'b100001) begin
          bad++;
          $display("FAIL color_bits: got %b expected 100001", {r1, g1, b1, r2, g2, b2});
        end
      end
      total++;
      if ((lat && !oe_n) || (sclk && !oe_n)) begin
        bad++;
        $display("FAIL overlap: lat=%b sclk=%b oe_n=%b expected no activity while oe_n=0", lat, sclk, oe_n);
      end
      if (lat) begin
        lats++;
        total++;
        if (edges != 64) begin
          bad++;
          $display("FAIL sclk_edges: got %0d expected 64", edges);
        end
        edges = 0;
      end
      prev = sclk;
    end
    total++;
    if (lats != 2) begin
      bad++;
      $display("FAIL lat_count: got %0d expected 2", lats);
    end
  endtask

  task automatic test_row5_addr();
    int n;
    int k;
    logic [11:0] last;
    logic [11:0] exp;
    logic [4:0]  prev_row;
    n = 0;
    while (pixel_addr !== 12'h140 && n < 5000) begin tick(); n++; end
    total++;
    if (pixel_addr !== 12'h140) begin
      bad++;
      $display("FAIL row5_start: got %h expected 140", pixel_addr);
    end
    last = pixel_addr;
    k = 1;
    n = 0;
    while (k < 128 && n < 1000) begin
      tick();
      n++;
      if (pixel_addr !== last) begin
        exp = (k % 2 == 0) ? 12'h140 + 12'(k / 2) : 12'h940 + 12'(k / 2);
        total++;
        if (pixel_addr !== exp) begin
          bad++;
          $display("FAIL row5_addr[%0d]: got %h expected %h", k, pixel_addr, exp);
        end
        last = pixel_addr;
        k++;
      end
    end
    total++;
    if (k != 128) begin
      bad++;
      $display("FAIL row5_addr_count: got %0d expected 128", k);
    end
    prev_row = row_addr;
    n = 0;
    while (lat !== 1'b1 && n < 20) begin prev_row = row_addr; tick(); n++; end
    total++;
    if (lat !== 1'b1 || prev_row !== 5'd5 || row_addr !== 5'd5) begin
      bad++;
      $display("FAIL row5_blank: lat=%b blank_row=%0d latch_row=%0d expected 1/5/5", lat, prev_row, row_addr);
    end
    tick();
    total++;
    if (lat !== 1'b0) begin
      bad++;
      $display("FAIL lat_width: got %b expected 0 one cycle later", lat);
    end
    n = 0;
    while (oe_n === 1'b0 && n < 2000) begin n++; tick(); end
    total++;
    if (n != 256) begin
      bad++;
      $display("FAIL row5_on: got %0d expected 256", n);
    end
  endtask

  task automatic test_frame();
    int n;
    int cyc;
    int idx;
    n = 0;
    while (frame_start !== 1'b1 && n < 23000) begin tick(); n++; end
    total++;
    if (frame_start !== 1'b1) begin
      bad++;
      $display("FAIL frame_wait: got %b expected 1", frame_start);
    end
    cyc = 0;
    idx = 0;
    do begin
      tick();
      cyc++;
      if (lat === 1'b1) begin
        total++;
        if (row_addr !== 5'(idx)) begin
          bad++;
          $display("FAIL frame_row[%0d]: got %0d expected %0d", idx, row_addr, idx);
        end
        idx++;
      end
    end while (frame_start !== 1'b1 && cyc < 30000);
    total++;
    if (cyc != 22592) begin
      bad++;
      $display("FAIL frame_period: got %0d expected 22592", cyc);
    end
    total++;
    if (idx != 32) begin
      bad++;
      $display("FAIL frame_lats: got %0d expected 32", idx);
    end
    n = 0;
    while (lat !== 1'b1 && n < 800) begin tick(); n++; end
    total++;
    if (lat !== 1'b1 || row_addr !== 5'd0) begin
      bad++;
      $display("FAIL row_wrap: lat=%b row=%0d expected 1/0", lat, row_addr);
    end
  endtask

  task automatic test_enable_drop();
    int n;
    logic fs_seen;
    n = 0;
    while (pixel_addr !== 12'h280 && n < 8000) begin tick(); n++; end
    total++;
    if (pixel_addr !== 12'h280) begin
      bad++;
      $display("FAIL row10_start: got %h expected 280", pixel_addr);
    end
    enable = 1'b0;
    n = 0;
    while (lat !== 1'b1 && n < 600) begin tick(); n++; end
    total++;
    if (lat !== 1'b1 || row_addr !== 5'd10) begin
      bad++;
      $display("FAIL row10_latch: lat=%b row=%0d expected 1/10", lat, row_addr);
    end
    tick();
    n = 0;
    while (oe_n === 1'b0 && n < 2000) begin n++; tick(); end
    total++;
    if (n != 256) begin
      bad++;
      $display("FAIL row10_on: got %0d expected 256", n);
    end
    for (int i = 0; i < 20; i++) begin
      total++;
      if ({oe_n, sclk, lat, frame_start, pixel_addr} !== {4'b1000, 12'hABF}) begin
        bad++;
        $display("FAIL idle_hold[%0d]: got oe_n=%b sclk=%b lat=%b fs=%b addr=%h expected 1/0/0/0/ABF",
                 i, oe_n, sclk, lat, frame_start, pixel_addr);
      end
      tick();
    end
    enable = 1'b1;
    fs_seen = 1'b0;
    n = 0;
    while (pixel_addr === 12'hABF && n < 10) begin
      tick();
      n++;
      if (frame_start === 1'b1) fs_seen = 1'b1;
    end
    total++;
    if (pixel_addr !== 12'h2C0) begin
      bad++;
      $display("FAIL resume_addr: got %h expected 2C0", pixel_addr);
    end
    total++;
    if (fs_seen !== 1'b0) begin
      bad++;
      $display("FAIL resume_frame_start: got %b expected 0", fs_seen);
    end
  endtask

  task automatic test_bcm();
    int edges;
    int n;
    logic prev;
    logic [5:0] exp;
    for (int p = 0; p < 4; p++) begin
      exp = (p < 2) ? 6'b100100 : 6'b000000;
      edges = 0;
      n = 0;
      prev = sclk;
      while (lat !== 1'b1 && n < 600) begin
        tick();
        n++;
        if (sclk && !prev) begin
          edges++;
          total++;
          if ({r1, g1, b1, r2, g2, b2} !== exp) begin
            bad++;
            $display("FAIL bcm_color[p%0d]: got %b expected %b", p, {r1, g1, b1, r2, g2, b2}, exp);
          end
        end
        prev = sclk;
      end
      total++;
      if (edges != 64) begin
        bad++;
        $display("FAIL bcm_edges[p%0d]: got %0d expected 64", p, edges);
      end
      tick();
      n = 0;
      while (oe_n === 1'b0 && n < 3000) begin n++; tick(); end
      total++;
      if (n != (256 << p)) begin
        bad++;
        $display("FAIL bcm_on[p%0d]: got %0d expected %0d", p, n, 256 << p);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    enable = 1'b0;
`ifdef HUB75_BCM_EN
    bcm_mode = 1'b1;
    test_reset();
    test_bcm();
`else
    bcm_mode = 1'b0;
    test_reset();
    test_colors();
    test_row5_addr();
    test_frame();
    test_enable_drop();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
